// File: rtl/tcp_buf_pkg.sv
// Shared defaults and state encoding for the TCP payload buffer write arbiter.
package tcp_buf_pkg;

  localparam int DATA_BITS_DEF = 512;
  localparam int MEM_DEPTH_DEF = 1024;
  localparam int LEN_BITS_DEF  = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tcp_rr_arb2.sv
// Two-way round-robin pick over an eligibility mask; only the pointer is stored.
module tcp_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] elig,
  input  logic       upd,
  input  logic       upd_owner,
  output logic [1:0] pick
);

  logic ptr_q, ptr_d;

  // After a burst the pointer favours whoever did not just own the buffer.
  always_comb begin
    ptr_d = ptr_q;
    if (upd) ptr_d = ~upd_owner;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

  always_comb begin
    pick = 2'b00;
    case (elig)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr_q ? 2'b10 : 2'b01;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/tcp_buf_wr_arbiter.sv
// Burst-granular write arbiter for the shared TCP payload buffer (0 = RX, 1 = app TX).
// state   | meaning
// IDLE    | waiting for an eligible request or a zero-length request
// XFER    | granted requester streams beats into the buffer
// DONE    | done pulse, grant released, back to IDLE next cycle
module tcp_buf_wr_arbiter
  import tcp_buf_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [LEN_BITS-1:0]  len0,
  input  logic [LEN_BITS-1:0]  len1,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic [DATA_BITS-1:0] data0,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ready0,
  output logic                 ready1,
  output logic                 done0,
  output logic                 done1,
  output logic [1:0]           grant,
  output logic                 buf_wr_en,
  output logic [DATA_BITS-1:0] buf_wr_data,
  input  logic                 rel_valid,
  input  logic [LEN_BITS-1:0]  rel_cnt,
  output logic [LEN_BITS-1:0]  free_cnt,
  output logic                 busy,
  output logic                 err
);

  localparam logic [LEN_BITS-1:0] DEPTH_L = LEN_BITS'(MEM_DEPTH);

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d, done_q, done_d;
  logic [LEN_BITS-1:0]  remaining_q, remaining_d;
  logic [LEN_BITS-1:0]  reserved_q, reserved_d;
  logic [LEN_BITS-1:0]  free_cnt_q, free_cnt_d;
  logic                 err_q, err_d, wr_en_q, wr_en_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

  logic [1:0]          req, zero_len, over_len, elig, arb_elig, pick, ready;
  logic                beat, last_beat;
  logic [LEN_BITS-1:0] grant_len;
  logic [LEN_BITS:0]   resv_sum;

  assign req = {req1, req0};

  // Zero-length requests are answered directly and take precedence over arbitration.
  always_comb begin
    zero_len = req & {len1 == '0, len0 == '0};
    over_len = req & {len1 > DEPTH_L, len0 > DEPTH_L};
    elig     = req & ~zero_len & {len1 <= free_cnt_q, len0 <= free_cnt_q};
    arb_elig = (state_q == ST_IDLE && zero_len == 2'b00) ? elig : 2'b00;
  end

  tcp_rr_arb2 u_rr (
    .clk       (clk),
    .resetn    (resetn),
    .elig      (arb_elig),
    .upd       (last_beat),
    .upd_owner (grant_q[1]),
    .pick      (pick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      done_q      <= 2'b00;
      remaining_q <= '0;
      reserved_q  <= '0;
      free_cnt_q  <= DEPTH_L;
      err_q       <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      reserved_q  <= reserved_d;
      free_cnt_q  <= free_cnt_d;
      err_q       <= err_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_comb begin
    beat      = |({valid1, valid0} & ready);
    last_beat = beat && (remaining_q == LEN_BITS'(1));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = 2'b00;
    remaining_d = remaining_q;
    grant_len   = '0;
    err_d       = err_q | (state_q == ST_IDLE && over_len != 2'b00);
    wr_en_d     = beat;
    wr_data_d   = wr_data_q;
    if (beat) wr_data_d = grant_q[1] ? data1 : data0;

    case (state_q)
      ST_IDLE: begin
        if (zero_len != 2'b00) begin
          done_d  = zero_len;
          state_d = ST_DONE;
        end else if (pick != 2'b00) begin
          grant_d     = pick;
          grant_len   = pick[1] ? len1 : len0;
          remaining_d = grant_len;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          remaining_d = remaining_q - LEN_BITS'(1);
          if (last_beat) begin
            done_d  = grant_q;
            grant_d = 2'b00;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Grant reservation and consumer release net in one step; underflow clamps.
    resv_sum   = {1'b0, reserved_q} + {1'b0, grant_len};
    reserved_d = resv_sum[LEN_BITS-1:0];
    if (rel_valid) begin
      if ({1'b0, rel_cnt} > resv_sum) begin
        reserved_d = '0;
        err_d      = 1'b1;
      end else begin
        reserved_d = LEN_BITS'(resv_sum - {1'b0, rel_cnt});
      end
    end
    free_cnt_d = DEPTH_L - reserved_d;
  end

  always_comb begin
    ready = 2'b00;
    if (state_q == ST_XFER) ready = grant_q;
  end

  assign ready0      = ready[0];
  assign ready1      = ready[1];
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign grant       = grant_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_data = wr_data_q;
  assign free_cnt    = free_cnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;

endmodule

// File: tb/tb_tcp_buf_wr_arbiter.sv
// Directed bench for tcp_buf_wr_arbiter: bursts, contention, space stall, backpressure, resets, errors.
module tb_tcp_buf_wr_arbiter;

  localparam int DW = 512;
  localparam int LW = 11;

  logic          clk, resetn;
  logic          req0, req1, valid0, valid1, rel_valid;
  logic [LW-1:0] len0, len1, rel_cnt;
  logic [DW-1:0] data0, data1;
  logic          ready0, ready1, done0, done1, buf_wr_en, busy, err;
  logic [1:0]    grant;
  logic [DW-1:0] buf_wr_data;
  logic [LW-1:0] free_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int done0_cnt = 0;

  tcp_buf_wr_arbiter dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
    .ready0(ready0), .ready1(ready1), .done0(done0), .done1(done1),
    .grant(grant), .buf_wr_en(buf_wr_en), .buf_wr_data(buf_wr_data),
    .rel_valid(rel_valid), .rel_cnt(rel_cnt), .free_cnt(free_cnt),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && buf_wr_en) wr_count++;
    if (resetn && done0) done0_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req0 = 0; req1 = 0; valid0 = 0; valid1 = 0; rel_valid = 0;
    len0 = '0; len1 = '0; rel_cnt = '0; data0 = '0; data1 = '0;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Streams nbeats beats for requester 'who', checking latency-1 write-through per beat.
  task automatic xfer(input int who, input int nbeats, input int first,
                      input bit toggle, input bit expect_done);
    int  sent = 0;
    int  cycles = 0;
    bit  v = 1'b1;
    bit  rdy, fire;
    while (sent < nbeats && cycles < nbeats * 3 + 40) begin
      if (who == 0) begin valid0 = v; data0 = DW'(first + sent); end
      else          begin valid1 = v; data1 = DW'(first + sent); end
      rdy = (who == 0) ? ready0 : ready1;
      if (rdy) check_eq("grant_owner", {62'd0, grant}, 64'(1 << who));
      fire = v && rdy;
      cyc();
      cycles++;
      check_eq("wr_en_latency", {63'd0, buf_wr_en}, {63'd0, fire});
      if (fire) begin
        check_eq("wr_data", buf_wr_data[63:0], 64'(first + sent));
        sent++;
      end
      if (toggle && rdy) v = ~v;
    end
    valid0 = 1'b0;
    valid1 = 1'b0;
    check_eq("beats_sent", 64'(sent), 64'(nbeats));
    if (expect_done) check_eq("done_pulse", {63'd0, (who == 0) ? done0 : done1}, 64'd1);
  endtask

  int wr_base, done_base;

  initial begin
    // 1: reset
    do_reset();
    check_eq("rst_free", 64'(free_cnt), 64'd1024);
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_wr_en", 64'(buf_wr_en), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_err", 64'(err), 64'd0);

    // 2: single burst of 4
    wr_base = wr_count; done_base = done0_cnt;
    req0 = 1; len0 = 11'd4;
    xfer(0, 4, 1, 1'b0, 1'b1);
    req0 = 0;
    check_eq("s_grant_off", 64'(grant), 64'd0);
    check_eq("s_ready_off", 64'(ready0), 64'd0);
    cyc();
    check_eq("s_done_once", 64'(done0), 64'd0);
    cyc();
    check_eq("s_free", 64'(free_cnt), 64'd1020);
    check_eq("s_writes", 64'(wr_count - wr_base), 64'd4);
    check_eq("s_done_cnt", 64'(done0_cnt - done_base), 64'd1);

    // 3: contention, pointer at 0 after reset
    do_reset();
    wr_base = wr_count;
    req0 = 1; len0 = 11'd8; req1 = 1; len1 = 11'd8;
    xfer(0, 8, 'h10, 1'b0, 1'b1);
    req0 = 0;
    xfer(1, 8, 'h20, 1'b0, 1'b1);
    req1 = 0;
    cyc();
    check_eq("c_free", 64'(free_cnt), 64'd1008);
    check_eq("c_writes", 64'(wr_count - wr_base), 64'd16);

    // 4: space stall until a release frees enough
    do_reset();
    req0 = 1; len0 = 11'd1000;
    xfer(0, 1000, 0, 1'b0, 1'b1);
    req0 = 0;
    req1 = 1; len1 = 11'd32;
    repeat (3) cyc();
    check_eq("sp_no_grant", 64'(grant), 64'd0);
    check_eq("sp_free24", 64'(free_cnt), 64'd24);
    rel_valid = 1; rel_cnt = 11'd100;
    cyc();
    rel_valid = 0; rel_cnt = '0;
    check_eq("sp_grant_wait", 64'(grant), 64'd0);
    check_eq("sp_free124", 64'(free_cnt), 64'd124);
    cyc();
    check_eq("sp_grant1", 64'(grant), 64'd2);
    check_eq("sp_free92", 64'(free_cnt), 64'd92);
    xfer(1, 32, 'h100, 1'b0, 1'b1);
    req1 = 0;

    // 5: backpressure, valid toggling during a 3-beat burst
    do_reset();
    wr_base = wr_count; done_base = done0_cnt;
    req0 = 1; len0 = 11'd3;
    xfer(0, 3, 'h30, 1'b1, 1'b1);
    req0 = 0;
    repeat (2) cyc();
    check_eq("bp_writes", 64'(wr_count - wr_base), 64'd3);
    check_eq("bp_done_cnt", 64'(done0_cnt - done_base), 64'd1);
    check_eq("bp_free", 64'(free_cnt), 64'd1021);

    // 6: async reset with 5 beats outstanding
    do_reset();
    req0 = 1; len0 = 11'd8;
    xfer(0, 3, 'h40, 1'b0, 1'b0);
    valid0 = 1;
    check_eq("ar_pre_grant", 64'(grant), 64'd1);
    #2 resetn = 0;
    #1;
    check_eq("ar_grant", 64'(grant), 64'd0);
    check_eq("ar_ready", 64'(ready0), 64'd0);
    check_eq("ar_wr_en", 64'(buf_wr_en), 64'd0);
    check_eq("ar_free", 64'(free_cnt), 64'd1024);
    check_eq("ar_busy", 64'(busy), 64'd0);

    // 7a: over-length request is never granted and flags err
    do_reset();
    req1 = 1; len1 = 11'd1100;
    cyc();
    check_eq("ol_err", 64'(err), 64'd1);
    cyc();
    check_eq("ol_grant", 64'(grant), 64'd0);
    req1 = 0;

    // 7b: release underflow, then zero-length request
    do_reset();
    check_eq("er_err_clr", 64'(err), 64'd0);
    req0 = 1; len0 = 11'd4;
    xfer(0, 4, 'h50, 1'b0, 1'b1);
    req0 = 0;
    cyc();
    check_eq("er_free1020", 64'(free_cnt), 64'd1020);
    rel_valid = 1; rel_cnt = 11'd10;
    cyc();
    rel_valid = 0; rel_cnt = '0;
    check_eq("er_uf_err", 64'(err), 64'd1);
    check_eq("er_uf_free", 64'(free_cnt), 64'd1024);
    repeat (3) cyc();
    check_eq("er_sticky", 64'(err), 64'd1);
    wr_base = wr_count;
    req0 = 1; len0 = '0;
    cyc();
    check_eq("z_done", 64'(done0), 64'd1);
    check_eq("z_grant", 64'(grant), 64'd0);
    req0 = 0;
    cyc();
    check_eq("z_done_off", 64'(done0), 64'd0);
    cyc();
    check_eq("z_writes", 64'(wr_count - wr_base), 64'd0);
    check_eq("z_free", 64'(free_cnt), 64'd1024);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcp_buf_wr_arbiter.md
Name: tcp_buf_wr_arbiter

Overview:
- Burst-granular write arbiter in front of the shared TCP payload data_buffer.
- Two requesters share the buffer's single write port: requester 0 is the RX segment path and requester 1 is the application TX path.
- Admits a burst only when enough buffer space can be reserved for it; whole bursts are granted round-robin.
- Tracks buffer occupancy through reservations made at grant time and releases signalled by the downstream consumer.

Parameters:
- DATA_BITS, 512, width of one buffer word / beat.
- MEM_DEPTH, 1024, buffer capacity in words.
- LEN_BITS, 11, width of burst length and count fields; must satisfy 2^LEN_BITS > MEM_DEPTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req0 / req1  in  1  burst request; held until done
- len0 / len1  in  LEN_BITS  burst length in beats; sampled at grant
- valid0 / valid1  in  1  write beat valid
- data0 / data1  in  DATA_BITS  write beat data
- ready0 / ready1  out  1  beat accepted when valid&ready
- done0 / done1  out  1  one-cycle pulse, burst complete
- grant  out  2  one-hot current owner
- buf_wr_en  out  1  write strobe to data_buffer
- buf_wr_data  out  DATA_BITS  write word to data_buffer
- rel_valid  in  1  consumer released words
- rel_cnt  in  LEN_BITS  number of words released
- free_cnt  out  LEN_BITS  MEM_DEPTH minus reserved words
- busy  out  1  state != IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset (async, resetn=0). All of the following take effect immediately:
  - state=IDLE, grant=0, ready*=0, done*=0, buf_wr_en=0, buf_wr_data=0
  - reserved=0 (so free_cnt=MEM_DEPTH), rr pointer=0, err=0
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - A requester is eligible when reqN=1 and lenN <= free_cnt.
  - If both are eligible, the one the rr pointer points at wins; otherwise the single eligible requester wins.
  - On a win, the next cycle has: grant one-hot, remaining=lenN, reserved += lenN, state=XFER.
  - An ineligible request (insufficient space) waits. It does not block the other requester.
  - If lenN=0 and reqN=1: doneN pulses next cycle, no grant, reserved unchanged, rr pointer unchanged.
  - lenN > MEM_DEPTH: never eligible; err set sticky.
- XFER:
  - readyN=1 only for the granted requester.
  - A beat occurs when validN&readyN. On each beat, the next cycle has buf_wr_en=1 and buf_wr_data=dataN (one registered stage, latency 1), and remaining decrements.
  - validN=0 stalls the burst with no timeout.
  - On the last beat (remaining==1 and a beat), readyN drops the following cycle and state=DONE.
- DONE:
  - doneN=1 for one cycle, grant=0, rr pointer points at the other requester, state=IDLE.
  - Minimum gap between bursts is 2 cycles (DONE, IDLE).
- req deassert mid-burst: ignored; the burst continues until len beats complete.
- Release:
  - On rel_valid, reserved -= rel_cnt.
  - A release in the same cycle as a grant nets both: reserved += len - rel_cnt.
  - Underflow (rel_cnt > reserved after netting): reserved clamps to 0 and err is set.
- free_cnt is registered and reflects reserved as of the previous edge. It never exceeds MEM_DEPTH and never goes negative.
- err is cleared only by reset.

Decomposition:
- Shared package tcp_buf_pkg: DATA_BITS, MEM_DEPTH and LEN_BITS defaults, plus the state enum (IDLE, XFER, DONE).
- One natural sub-module: tcp_rr_arb2, a 2-way round-robin pick with an eligibility mask. It is combinational apart from its pointer register.
- The reservation counter and beat pipeline stay in the top level.

Test Plan:
1. Reset: hold resetn=0 for 5 cycles, then release → free_cnt=1024, grant=0, buf_wr_en=0, busy=0.
2. Single burst: req0, len0=4, valid0 held high with data 1..4 → buf_wr_en high for 4 consecutive cycles carrying 1..4, each one cycle after its beat; done0 pulses once; free_cnt=1020.
3. Contention: req0 and req1 both asserted with len=8, rr pointer=0 → requester 0 is served first, then requester 1; 16 writes total in grant order; free_cnt=1008.
4. Space stall: after 1000 words are reserved, req1 with len1=32 → no grant. Then rel_valid with rel_cnt=100 → grant1 two cycles later, and free_cnt=92 after the grant.
5. Backpressure: valid0 toggles 1,0,1,0 during a len=3 burst → exactly 3 buf_wr_en pulses, remaining stalls while valid0=0, done0 after the third beat.
6. Async reset mid-XFER: resetn=0 while remaining=5 → grant, ready* and buf_wr_en go to 0 immediately; free_cnt=1024.
7. Errors: rel_cnt=10 with reserved=4 → reserved=0 and err=1, with err still 1 afterwards. Also req0 with len0=0 → done0 pulses with no writes.
